count_serializer: RTL and testbench

downstream of the dual 64-bit counter. Snapshots one count and streams it out as a byte frame over a valid/ready link.

Interface
REQ-001 Parameter HEADER, default 8'hA5, frame marker; bit 0 is replaced by the captured select.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 Count0  input  64  counter output 0.
REQ-005 Count1  input  64  counter output 1.
REQ-006 Start  input  1  snapshot request, sampled each rising edge.
REQ-007 Sel  input  1  source select sampled with Start: 0 = Count0, 1 = Count1.
REQ-008 Clear  input  1  synchronous clear of Overrun.
REQ-009 OutReady  input  1  downstream ready.
REQ-010 OutData  output  8  current frame byte.
REQ-011 OutValid  output  1  OutData valid.
REQ-012 OutLast  output  1  marks the final (checksum) byte of the frame.
REQ-013 Busy  output  1  high whenever state != IDLE.
REQ-014 Overrun  output  1  sticky flag: a Start was dropped.

Function
REQ-015 FSM states SHALL be IDLE, HDR, DATA, CSUM, with transitions:
- IDLE->HDR on Start.
- HDR->DATA on handshake.
- DATA->CSUM on handshake of byte index 7.
- CSUM->IDLE on handshake.
REQ-016 A handshake SHALL be defined as OutValid && OutReady at a rising edge.
REQ-017 In IDLE, Start SHALL capture a 64-bit snapshot (Sel ? Count1 : Count0) and a select bit sel_q.
REQ-018 OutValid SHALL rise in the cycle after Start is sampled (latency 1).
REQ-019 The frame SHALL contain exactly 10 bytes, in this order:
- header {HEADER[7:1], sel_q};
- snapshot bytes [7:0], [15:8], ... [63:56], LSB byte first;
- checksum.
REQ-020 The checksum byte SHALL be the XOR of the header byte and all 8 data bytes.
REQ-021 OutLast SHALL be 1 only while the checksum byte is presented.
REQ-022 OutValid SHALL be 1 in HDR, DATA and CSUM, and 0 in IDLE.
REQ-023 While OutValid && !OutReady, OutData and OutLast SHALL hold stable; the frame advances only on a handshake.
REQ-024 The snapshot SHALL be unaffected by Count0/Count1 changes after capture.
REQ-025 Start while Busy (including the cycle of the final CSUM handshake) SHALL be ignored and SHALL set Overrun.
REQ-026 Overrun SHALL clear on Clear; if Clear and a dropped Start occur in the same cycle, Overrun SHALL be 1 (set wins).
REQ-027 After the CSUM handshake, Busy SHALL be 0 in the next cycle, and a new Start SHALL be accepted from that cycle.
REQ-028 The byte index SHALL be 3 bits, running 0..7, with no wrap beyond 7 within a frame.

Reset
REQ-029 Reset=0 SHALL immediately force state IDLE and zero every output and register: OutData=8'h00, OutValid=0, OutLast=0, Busy=0, Overrun=0, snapshot=0, byte index=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame; no remaining bytes are emitted after release.
REQ-031 After reset release, the block SHALL remain IDLE until the next Start.

Verification
REQ-032 Basic frame:
- Stimulus: Count0=64'h14, Sel=0, Start pulse, OutReady=1.
- Required: bytes A4,14,00,00,00,00,00,00,00,B0 on 10 consecutive cycles, starting 1 cycle after Start; OutLast on B0; Busy low the next cycle.
REQ-033 Second source:
- Stimulus: Count1=64'h0102030405060708, Sel=1, Start.
- Required: bytes A5,08,07,06,05,04,03,02,01,AD.
REQ-034 Backpressure:
- Stimulus: OutReady low for 3 cycles while the header is presented; Count0 changed during the frame.
- Required: header held for 4 cycles; captured data bytes unchanged.
REQ-035 Overrun:
- Stimulus: Start during DATA.
- Required: frame unaffected and Overrun=1.
- Then Clear with a simultaneous Start in CSUM: Overrun stays 1. Clear alone: Overrun=0.
REQ-036 Reset mid-frame:
- Stimulus: Reset=0 asynchronously during DATA.
- Required: all outputs 0 before the next edge; after release, no bytes until a new Start.

---
 rtl/count_serializer.sv | 115 +++++++++++
 tb/tb_count_serializer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/count_serializer.sv
// Snapshots one of two 64-bit counts and streams it as a 10-byte frame:
// header, eight data bytes LSB first, XOR checksum.
module count_serializer #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [63:0] Count0,
  input  logic [63:0] Count1,
  input  logic        Start,
  input  logic        Sel,
  input  logic        Clear,
  input  logic        OutReady,
  output logic [7:0]  OutData,
  output logic        OutValid,
  output logic        OutLast,
  output logic        Busy,
  output logic        Overrun
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    CSUM
  } state_t;

  state_t      state;
  logic [63:0] snap;
  logic        sel_q;
  logic [2:0]  idx;
  logic [7:0]  csum;

  logic        fire;
  logic [2:0]  nxt;
  logic [7:0]  hdr_now;
  logic [7:0]  hdr_cap;
  logic [7:0]  next_byte;

  assign fire      = OutValid && OutReady;
  assign nxt       = idx + 3'd1;
  assign hdr_now   = {HEADER[7:1], Sel};
  assign hdr_cap   = {HEADER[7:1], sel_q};
  assign next_byte = snap[{nxt, 3'b000} +: 8];

  // csum accumulates data bytes only; header folds in at the end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      snap     <= '0;
      sel_q    <= 1'b0;
      idx      <= '0;
      csum     <= '0;
      OutData  <= '0;
      OutValid <= 1'b0;
      OutLast  <= 1'b0;
      Busy     <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      if (Clear)
        Overrun <= 1'b0;
      if (Start && state != IDLE)
        Overrun <= 1'b1;

      unique case (state)
        IDLE: begin
          if (Start) begin
            state    <= HDR;
            snap     <= Sel ? Count1 : Count0;
            sel_q    <= Sel;
            idx      <= '0;
            csum     <= '0;
            OutData  <= hdr_now;
            OutValid <= 1'b1;
            OutLast  <= 1'b0;
            Busy     <= 1'b1;
          end
        end
        HDR: begin
          if (fire) begin
            state   <= DATA;
            idx     <= '0;
            OutData <= snap[7:0];
            csum    <= snap[7:0];
          end
        end
        DATA: begin
          if (fire) begin
            if (idx == 3'd7) begin
              state   <= CSUM;
              OutData <= csum ^ hdr_cap;
              OutLast <= 1'b1;
            end else begin
              idx     <= nxt;
              OutData <= next_byte;
              csum    <= csum ^ next_byte;
            end
          end
        end
        CSUM: begin
          if (fire) begin
            state    <= IDLE;
            idx      <= '0;
            OutData  <= '0;
            OutValid <= 1'b0;
            OutLast  <= 1'b0;
            Busy     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_serializer.sv
// Bench for count_serializer: directed frames plus random traffic
// against a byte-queue reference model.
module tb_count_serializer;

  typedef logic [7:0] bq_t[$];

  logic        Clk;
  logic        Reset;
  logic [63:0] Count0;
  logic [63:0] Count1;
  logic        Start;
  logic        Sel;
  logic        Clear;
  logic        OutReady;
  logic [7:0]  OutData;
  logic        OutValid;
  logic        OutLast;
  logic        Busy;
  logic        Overrun;

  int   n_chk;
  int   n_fail;
  bq_t  q;
  bq_t  rx_q;
  logic m_ovr;

  count_serializer #(.HEADER(8'hA5)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Count0(Count0),
    .Count1(Count1),
    .Start(Start),
    .Sel(Sel),
    .Clear(Clear),
    .OutReady(OutReady),
    .OutData(OutData),
    .OutValid(OutValid),
    .OutLast(OutLast),
    .Busy(Busy),
    .Overrun(Overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bq_t mk_frame(input logic [63:0] s,
                                   input logic sel);
    bq_t f;
    logic [7:0] h;
    logic [7:0] b;
    logic [7:0] x;
    h = (8'hA5 & 8'hFE) | {7'd0, sel};
    f.push_back(h);
    x = h;
    for (int i = 0; i < 8; i++) begin
      b = 8'((s >> (8 * i)) & 64'hFF);
      f.push_back(b);
      x = x ^ b;
    end
    f.push_back(x);
    return f;
  endfunction

  // Reference: queue of bytes still to be delivered in the current frame
  always @(posedge Clk or negedge Reset) begin
    bit   busy_pre;
    bq_t  nf;
    if (!Reset) begin
      q.delete();
      m_ovr = 1'b0;
    end else begin
      busy_pre = q.size() > 0;
      if (busy_pre && OutReady)
        void'(q.pop_front());
      if (Clear)
        m_ovr = 1'b0;
      if (Start) begin
        if (busy_pre) begin
          m_ovr = 1'b1;
        end else begin
          nf = mk_frame(Sel ? Count1 : Count0, Sel);
          foreach (nf[i]) q.push_back(nf[i]);
        end
      end
    end
  end

  always @(negedge Clk) begin
    chk("valid", {63'd0, OutValid}, {63'd0, q.size() > 0});
    chk("data", {56'd0, OutData},
        {56'd0, (q.size() > 0) ? q[0] : 8'h00});
    chk("last", {63'd0, OutLast}, {63'd0, q.size() == 1});
    chk("busy", {63'd0, Busy}, {63'd0, q.size() > 0});
    chk("overrun", {63'd0, Overrun}, {63'd0, m_ovr});
    if (OutValid && OutReady)
      rx_q.push_back(OutData);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start(input logic sel);
    Sel   = sel;
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!Busy) break;
      step();
    end
    chk("idle_timeout", {63'd0, Busy}, 64'd0);
  endtask

  task automatic cmp_rx(input string tag, input bq_t e);
    chk({tag, "_len"}, 64'(rx_q.size()), 64'(e.size()));
    for (int i = 0; i < e.size() && i < rx_q.size(); i++)
      chk(tag, {56'd0, rx_q[i]}, {56'd0, e[i]});
  endtask

  initial begin
    bq_t e;
    logic [63:0] v;
    n_chk    = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    Count0   = '0;
    Count1   = '0;
    Start    = 1'b0;
    Sel      = 1'b0;
    Clear    = 1'b0;
    OutReady = 1'b1;
    #1 Reset = 1'b0;
    #1;
    chk("rst_valid", {63'd0, OutValid}, 64'd0);
    chk("rst_data", {56'd0, OutData}, 64'd0);
    repeat (2) step();
    Reset = 1'b1;
    repeat (3) step();

    // basic frame from Count0
    rx_q.delete();
    Count0 = 64'h14;
    pulse_start(1'b0);
    chk("lat1_valid", {63'd0, OutValid}, 64'd1);
    chk("lat1_hdr", {56'd0, OutData}, 64'hA4);
    wait_idle(40);
    e = '{8'hA4, 8'h14, 8'h00, 8'h00, 8'h00,
          8'h00, 8'h00, 8'h00, 8'h00, 8'hB0};
    cmp_rx("basic", e);

    // second source
    rx_q.delete();
    Count1 = 64'h0102030405060708;
    pulse_start(1'b1);
    wait_idle(40);
    e = '{8'hA5, 8'h08, 8'h07, 8'h06, 8'h05,
          8'h04, 8'h03, 8'h02, 8'h01, 8'hAD};
    cmp_rx("sel1", e);

    // backpressure on header, Count0 churning
    rx_q.delete();
    v        = 64'hDEADBEEF01234567;
    Count0   = v;
    OutReady = 1'b0;
    pulse_start(1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_hdr", {56'd0, OutData}, 64'hA4);
      Count0 = {$urandom, $urandom};
      if (i < 3) step();
    end
    OutReady = 1'b1;
    for (int i = 0; i < 40 && Busy; i++) begin
      Count0 = {$urandom, $urandom};
      step();
    end
    wait_idle(5);
    cmp_rx("bp", mk_frame(v, 1'b0));

    // overrun: Start during DATA, then Clear+Start in CSUM, then Clear
    rx_q.delete();
    v      = {$urandom, $urandom};
    Count1 = v;
    pulse_start(1'b1);
    repeat (3) step();
    pulse_start(1'b0);
    chk("ovr_set", {63'd0, Overrun}, 64'd1);
    for (int i = 0; i < 20 && !OutLast; i++) step();
    chk("ovr_csum", {63'd0, OutLast}, 64'd1);
    Clear = 1'b1;
    pulse_start(1'b0);
    Clear = 1'b0;
    chk("ovr_setwins", {63'd0, Overrun}, 64'd1);
    chk("ovr_done", {63'd0, Busy}, 64'd0);
    cmp_rx("ovr_frame", mk_frame(v, 1'b1));
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    chk("ovr_clr", {63'd0, Overrun}, 64'd0);

    // asynchronous reset mid-frame
    Count0 = {$urandom, $urandom};
    pulse_start(1'b0);
    repeat (4) step();
    #2 Reset = 1'b0;
    #1;
    chk("arst_valid", {63'd0, OutValid}, 64'd0);
    chk("arst_data", {56'd0, OutData}, 64'd0);
    chk("arst_last", {63'd0, OutLast}, 64'd0);
    chk("arst_busy", {63'd0, Busy}, 64'd0);
    step();
    Reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("arst_idle", {63'd0, OutValid}, 64'd0);
    end

    // random traffic
    for (int i = 0; i < 600; i++) begin
      Count0   = {$urandom, $urandom};
      Count1   = {$urandom, $urandom};
      Start    = ($urandom_range(0, 7) == 0);
      Sel      = 1'($urandom);
      Clear    = ($urandom_range(0, 15) == 0);
      OutReady = ($urandom_range(0, 3) != 0);
      step();
    end
    Start    = 1'b0;
    Clear    = 1'b0;
    OutReady = 1'b1;
    step();
    wait_idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
